// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: per-boundary control widths and the NOP
// control encodings each boundary passes as CTRL_RST to pipe_stage_reg.
package pipe_pkg;

  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_CTRL_W = 7;

  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_DATA_W  = 96;
  localparam int EXMEM_DATA_W = 64;
  localparam int MEMWB_DATA_W = 64;

  // A NOP is any control word with regWrite/memWrite low; all-zero is the simplest
  localparam logic [IFID_CTRL_W-1:0]  IFID_NOP_CTRL  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_NOP_CTRL  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_NOP_CTRL = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_NOP_CTRL = '0;

  function automatic logic [1:0] beatCount(input logic mHeld, input logic sHeld);
    return {1'b0, mHeld} + {1'b0, sHeld};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data register. Flush and clear drop the beat and park the
// control field at CTRL_RST; data is only touched by reset and load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Priority: reset, then flush, then load, then clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_RST;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= CTRL_RST;
    end else if (load) begin
      valid <= 1'b1;
      data  <= dataIn;
      ctrl  <= ctrlIn;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_RST;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline register with flush and control bubbling.
// Define PIPE_SKID_EN to add a skid slot so in_ready comes straight from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              mValid;
  logic              mLoad;
  logic              mClear;
  logic [DATA_W-1:0] mDataIn;
  logic [CTRL_W-1:0] mCtrlIn;
  logic              xferIn;
  logic              xferOut;

  assign xferIn    = in_valid && in_ready;
  assign xferOut   = mValid && out_ready;
  assign out_valid = mValid;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) mainSlot (
    .clk    (clk),
    .resetn (resetn),
    .load   (mLoad),
    .clear  (mClear),
    .flush  (flush),
    .dataIn (mDataIn),
    .ctrlIn (mCtrlIn),
    .valid  (mValid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

`ifdef PIPE_SKID_EN
  logic              sValid;
  logic              sLoad;
  logic              sClear;
  logic [DATA_W-1:0] sData;
  logic [CTRL_W-1:0] sCtrl;

  assign in_ready = !sValid;

  // S refills M first; while S is full in_ready is low, so no input competes
  always_comb begin
    mLoad   = 1'b0;
    mDataIn = in_data;
    mCtrlIn = in_ctrl;
    sLoad   = 1'b0;
    sClear  = 1'b0;
    if (xferOut && sValid) begin
      mLoad   = 1'b1;
      mDataIn = sData;
      mCtrlIn = sCtrl;
      sClear  = 1'b1;
    end else if (xferIn && (!mValid || out_ready)) begin
      mLoad = 1'b1;
    end else if (xferIn) begin
      sLoad = 1'b1;
    end
  end

  assign mClear = xferOut && !mLoad;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) skidSlot (
    .clk    (clk),
    .resetn (resetn),
    .load   (sLoad),
    .clear  (sClear),
    .flush  (flush),
    .dataIn (in_data),
    .ctrlIn (in_ctrl),
    .valid  (sValid),
    .data   (sData),
    .ctrl   (sCtrl)
  );

  assign occupancy = beatCount(mValid, sValid);
`else
  assign in_ready  = !mValid || out_ready;
  assign mLoad     = xferIn;
  assign mClear    = xferOut && !xferIn;
  assign mDataIn   = in_data;
  assign mCtrlIn   = in_ctrl;
  assign occupancy = beatCount(mValid, 1'b0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg in either build (PIPE_SKID_EN defined or not),
// checked against a queue model of the beats the stage holds.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam logic [CW-1:0] CRST = 8'hA5;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // Model: a FIFO of held beats, capacity 2 with skid, 1 without
  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] lastData = '0;

  function automatic logic expReady();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic [CW-1:0] expCtrl();
    if (q.size() > 0) return q[0].ctrl;
    return CRST;
  endfunction

  task automatic cycle();
    logic  xin;
    logic  xout;
    beat_t b;
    xin  = in_valid && expReady();
    xout = (q.size() > 0) && out_ready;
    b.data = in_data;
    b.ctrl = in_ctrl;
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      lastData = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back(b);
    end
    if (q.size() > 0) lastData = q[0].data;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data = 32'hDEAD_BEEF; in_ctrl = 8'h3C;
    repeat (3) cycle();
    resetn = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_ctrl !== CRST) begin failures++; $display("[TB] FAIL reset_ctrl got=%h want=%h", out_ctrl, CRST); end
    checks++; if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i + 16);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready beat=%0d got=%b want=1", i, in_ready); end
      cycle();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        failures++; $display("[TB] FAIL stream_out beat=%0d got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, i);
      end
      checks++; if (occupancy > 2'd1) begin failures++; $display("[TB] FAIL stream_occ got=%0d want<=1", occupancy); end
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] src [3];
    int idx;
    int got;
    src[0] = 32'hA; src[1] = 32'hB; src[2] = 32'hC;
    idx = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = src[idx]; in_ctrl = CW'(idx + 1);
      #1;
      checks++; if (in_ready !== expReady()) begin failures++; $display("[TB] FAIL stall_ready cyc=%0d got=%b want=%b", c, in_ready, expReady()); end
      if (expReady()) idx++;
      cycle();
    end
    in_data = src[idx]; in_ctrl = CW'(idx + 1);
    #1;
    checks++; if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin failures++; $display("[TB] FAIL stall_occ got=%0d want=%0d", occupancy, SKID ? 2 : 1); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready got=%b want=0", in_ready); end
    checks++; if (out_data !== 32'hA || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_head got=%h want=a", out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== !SKID) begin failures++; $display("[TB] FAIL stall_release_ready got=%b want=%b", in_ready, !SKID); end
    for (int c = 0; c < 12 && got < 3; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin in_data = src[idx]; in_ctrl = CW'(idx + 1); end
      #1;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== src[got]) begin failures++; $display("[TB] FAIL stall_order n=%0d got=%h want=%h", got, out_data, src[got]); end
        got++;
      end
      if (in_valid && expReady()) idx++;
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (got != 3) begin failures++; $display("[TB] FAIL stall_timeout got=%0d beats want=3", got); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_data = 32'h100 + DW'(c); in_ctrl = 8'h20;
      cycle();
    end
    checks++; if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin failures++; $display("[TB] FAIL flush_fill got=%0d want=%0d", occupancy, SKID ? 2 : 1); end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hD; in_ctrl = 8'h77;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b want=0", out_valid); end
    checks++; if (out_ctrl !== CRST) begin failures++; $display("[TB] FAIL flush_ctrl got=%h want=%h", out_ctrl, CRST); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL flush_occ got=%0d want=0", occupancy); end
    checks++; if (out_data !== 32'h100) begin failures++; $display("[TB] FAIL flush_data got=%h want=100", out_data); end
    repeat (4) begin
      cycle();
      checks++; if (out_valid !== 1'b0 || out_data === 32'hD) begin failures++; $display("[TB] FAIL flush_leak got v=%b d=%h want v=0", out_valid, out_data); end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1234; in_ctrl = 8'hFF;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'hFF) begin failures++; $display("[TB] FAIL bubble_load got v=%b c=%h want v=1 c=ff", out_valid, out_ctrl); end
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CRST) begin failures++; $display("[TB] FAIL bubble_ctrl got v=%b c=%h want v=0 c=%h", out_valid, out_ctrl, CRST); end
    checks++; if (out_data !== 32'h1234) begin failures++; $display("[TB] FAIL bubble_data got=%h want=1234", out_data); end
  endtask

  task automatic test_reset_priority();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h11;
    cycle();
    resetn = 1'b0; flush = 1'b1; in_data = 32'h66;
    cycle();
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_data !== '0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++; $display("[TB] FAIL reset_over_flush got v=%b d=%h o=%0d want v=0 d=0 o=0", out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] seq;
    seq = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_data   = seq;
      in_ctrl   = CW'($urandom_range(0, 255));
      #1;
      checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, q.size() > 0); end
      checks++; if (out_data !== lastData) begin failures++; $display("[TB] FAIL rand_data cyc=%0d got=%h want=%h", c, out_data, lastData); end
      checks++; if (out_ctrl !== expCtrl()) begin failures++; $display("[TB] FAIL rand_ctrl cyc=%0d got=%h want=%h", c, out_ctrl, expCtrl()); end
      checks++; if (in_ready !== expReady()) begin failures++; $display("[TB] FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready, expReady()); end
      checks++; if (occupancy !== 2'(q.size())) begin failures++; $display("[TB] FAIL rand_occ cyc=%0d got=%0d want=%0d", c, occupancy, q.size()); end
      if (in_valid && expReady()) seq++;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline register for the RV32 core. It generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It adds valid/ready backpressure, a synchronous flush, control-field bubbling, and an optional skid buffer that registers the upstream ready path. Every stage boundary instantiates it with its own payload widths.

## Interface
Parameters:
- DATA_W, 64: width of the data payload (e.g. aluResult + readData); never cleared except by reset.
- CTRL_W, 8: width of the control payload (regWrite, memToReg, rd, ...); forced to CTRL_RST whenever the stage holds a bubble.
- CTRL_RST, '0: control value that encodes a harmless no-op.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream holds a valid beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous kill of all held beats (branch mispredict, trap).
- out_valid  out  1  stage presents a valid beat.
- out_ready  in  1  downstream consumes the beat.
- out_data  out  DATA_W  registered data payload.
- out_ctrl  out  CTRL_W  registered control payload; equals CTRL_RST whenever out_valid=0.
- occupancy  out  2  number of beats held: 0, 1, or 2 (2 only with skid).

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Main register M drives the outputs.
- Skid register S exists only with PIPE_SKID_EN.

Without skid:
- in_ready = !M.valid || out_ready (combinational).
- M loads on a transfer in. M.valid clears on a transfer out with no transfer in.

With skid:
- in_ready = !S.valid (registered).
- If a transfer in happens while M is valid and out_ready=0, the beat goes into S.
- If a transfer out happens with S valid, S moves into M and S empties.
- When S is valid, in_ready=0, so input and S-to-M never compete.

Bubble handling:
- Any cycle that leaves M invalid loads CTRL_RST into M.ctrl.
- Data is left unchanged, which saves enables.

Flush:
- Clears M.valid and S.valid and loads CTRL_RST into both ctrl fields.
- Has priority over a simultaneous transfer in: that beat is dropped, even though in_ready was high.

Reset:
- Resetn is synchronous and has priority over everything, flush included.

## Timing
- Reset values: out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0.
- in_ready after reset is 1 in both configurations.
- Latency: 1 cycle from transfer in to out_valid when the stage is empty.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure propagation:
  - Without skid: same cycle, through the combinational path.
  - With skid: one cycle later, with S absorbing the in-flight beat.
- No beat is lost or duplicated under any out_ready pattern.
- Order is strictly FIFO.
- out_valid is never deasserted without a transfer out, except by flush or reset.

## Configuration
- PIPE_SKID_EN defined:
  - 2-entry storage with S.
  - in_ready driven straight from a flop.
  - occupancy can reach 2.
- PIPE_SKID_EN undefined:
  - S is absent.
  - in_ready is combinational from out_ready.
  - occupancy is at most 1.

## Structure
- Shared package pipe_pkg holds:
  - stage-specific payload widths (MEMWB_CTRL_W, EXMEM_CTRL_W, ...);
  - NOP control constants used as CTRL_RST.
- One sub-module: pipe_slot, a single valid+ctrl+data register with load, clear-ctrl and flush. M and S are each one instance of it.

## Test plan
- Reset: hold resetn=0 for 3 cycles with in_valid=1 → out_valid=0, out_ctrl=CTRL_RST, out_data=0, in_ready=1 after release.
- Streaming: out_ready=1, in_data=1..8 on consecutive cycles → out_data=1..8 one cycle later, out_valid high 8 cycles, occupancy≤1.
- Stall:
  - Setup: out_ready low for 3 cycles while feeding 0xA, 0xB, 0xC.
  - Skid build: 0xA held in M, 0xB in S, in_ready=0, occupancy=2; 0xC waits upstream.
  - Non-skid build: in_ready drops in the same cycle as out_ready; occupancy=1.
  - Expected: after release, 0xA, 0xB, 0xC emerge in order.
- Flush with concurrent input: occupancy=2, flush=1 with in_valid=1 and in_data=0xD → next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0; 0xD never appears.
- Bubble control: in_ctrl=0xFF accepted, consumed, then in_valid=0 → out_ctrl returns to CTRL_RST while out_data keeps its last value.
- Random out_ready and in_valid, 10k cycles, both configurations → a scoreboard shows no loss, duplication, or reordering.
